// File: rtl/ysyx_22040632_mc_ctrl.sv
// Multi-cycle core control sequencer.
// It steps each instruction through fetch request, fetch wait, decode and execute.
// The sequencer halts on ebreak, on a misaligned next-pc, or when execute times out.
// Optional feature: define YSYX_22040632_INSTRET_EN to build the 64-bit retired-instruction
// counter. When the macro is undefined, instret is tied to zero.
module ysyx_22040632_mc_ctrl #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC     = 'h8000_0000,
  parameter int unsigned     EXEC_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  // decode / execute handshake
  output logic [31:0]     inst,
  output logic            inst_valid,
  input  logic            exu_done,
  input  logic            exu_redirect,
  input  logic [XLEN-1:0] exu_next_pc,
  // architectural status
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halt,
  output logic [1:0]      trap,
  output logic [63:0]     instret
);

  localparam logic [31:0] Ebreak = 32'h0010_0073;

  localparam logic [1:0] TrapEbreak   = 2'd0;
  localparam logic [1:0] TrapMisalign = 2'd1;
  localparam logic [1:0] TrapTimeout  = 2'd2;

  // A zero timeout would be meaningless, so allow at least one execute cycle.
  localparam int unsigned   TimeoutCyc = (EXEC_TIMEOUT == 0) ? 1 : EXEC_TIMEOUT;
  localparam int unsigned   CntW       = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutCyc - 1);

  typedef enum logic [2:0] {
    StReset,
    StFetchReq,
    StFetchWait,
    StDecode,
    StExec,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [1:0]        trap_q, trap_d;
  logic [CntW-1:0]   exec_cnt_q, exec_cnt_d;
  logic [XLEN-1:0]   next_pc;

  // Candidate successor pc; the sum wraps naturally at 2^XLEN.
  always_comb begin
    next_pc = exu_redirect ? exu_next_pc : (pc_q + XLEN'(4));
  end

  // Next-state logic plus the per-state strobes.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    trap_d         = trap_q;
    exec_cnt_d     = exec_cnt_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    retire         = 1'b0;

    unique case (state_q)
      StReset: begin
        state_d = StFetchReq;
      end

      StFetchReq: begin
        imem_req_valid = 1'b1;
        // Any response seen here belongs to no request of ours and is dropped.
        if (imem_req_ready) begin
          state_d = StFetchWait;
        end
      end

      StFetchWait: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = StDecode;
        end
      end

      StDecode: begin
        inst_valid = 1'b1;
        exec_cnt_d = '0;
        if (inst_q == Ebreak) begin
          // ebreak retires here and leaves pc untouched.
          retire  = 1'b1;
          trap_d  = TrapEbreak;
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        if (exu_done) begin
          retire = 1'b1;
          if (next_pc[1:0] != 2'b00) begin
            trap_d  = TrapMisalign;
            state_d = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = StFetchReq;
          end
        end else if (exec_cnt_q == CntLast) begin
          trap_d  = TrapTimeout;
          state_d = StHalt;
        end else begin
          exec_cnt_d = exec_cnt_q + CntW'(1);
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StReset;
      end
    endcase
  end

  // Core control state; reset forces the architectural reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReset;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      trap_q     <= TrapEbreak;
      exec_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      trap_q     <= trap_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

`ifdef YSYX_22040632_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Retired-instruction counter, wrapping at 2^64.
  always_comb begin
    instret_d = retire ? (instret_q + 64'd1) : instret_q;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

  assign imem_req_addr = pc_q;
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign trap          = trap_q;
  assign halt          = (state_q == StHalt);

endmodule

// File: tb/tb_ysyx_22040632_mc_ctrl.sv
// Self-checking bench for ysyx_22040632_mc_ctrl.
// Stimulus tasks walk each instruction through the fetch/decode/execute protocol and keep
// expected outputs up to date. A negedge process compares every output on every cycle.
module tb_ysyx_22040632_mc_ctrl;
  localparam int unsigned XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam int unsigned TO     = 4;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] JAL    = 32'h0080_006f;

  logic            clk;
  logic            rst_n;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic [31:0]     inst;
  logic            inst_valid;
  logic            exu_done;
  logic            exu_redirect;
  logic [XLEN-1:0] exu_next_pc;
  logic [XLEN-1:0] pc;
  logic            retire;
  logic            halt;
  logic [1:0]      trap;
  logic [63:0]     instret;

  ysyx_22040632_mc_ctrl #(
    .XLEN        (XLEN),
    .RESET_PC    (RST_PC),
    .EXEC_TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .exu_done      (exu_done),
    .exu_redirect  (exu_redirect),
    .exu_next_pc   (exu_next_pc),
    .pc            (pc),
    .retire        (retire),
    .halt          (halt),
    .trap          (trap),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int cyc_n;
  int last_ret;
  bit check_en;

  // Expected architectural view.
  logic [63:0] m_pc;
  logic [63:0] m_instret;
  logic [31:0] m_inst;
  logic        m_halt;
  logic [1:0]  m_trap;
  logic        e_req;
  logic        e_ivalid;
  logic        e_retire;
  logic [63:0] e_ir;
  logic [63:0] lit_ir;

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc_n = 0;
    last_ret = -1;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // Per-cycle comparison against the expected view.
  always @(negedge clk) begin
    if (check_en) begin
`ifdef YSYX_22040632_INSTRET_EN
      e_ir = m_instret;
`else
      e_ir = 64'd0;
`endif
      chk("imem_req_valid", {63'd0, imem_req_valid}, {63'd0, e_req});
      chk("imem_req_addr", imem_req_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("inst", {32'd0, inst}, {32'd0, m_inst});
      chk("inst_valid", {63'd0, inst_valid}, {63'd0, e_ivalid});
      chk("retire", {63'd0, retire}, {63'd0, e_retire});
      chk("halt", {63'd0, halt}, {63'd0, m_halt});
      chk("trap", {62'd0, trap}, {62'd0, m_trap});
      chk("instret", instret, e_ir);
      if (retire === 1'b1) last_ret = cyc_n;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_pc = RST_PC;
    m_inst = 32'd0;
    m_instret = 64'd0;
    m_halt = 1'b0;
    m_trap = 2'd0;
    e_req = 1'b0;
    e_ivalid = 1'b0;
    e_retire = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;  // late response from the abandoned fetch
    imem_rsp_data = EBREAK;
    exu_done = 1'b0;
    exu_redirect = 1'b0;
    #1;
    chk("async_rst_pc", pc, RST_PC);
    chk("async_rst_req", {63'd0, imem_req_valid}, 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    e_req = 1'b1;
  endtask

  // Entry: DUT is in its fetch-request cycle.
  task automatic run_instr(input logic [31:0] ins, input int rdy_dly, input int rsp_dly,
                           input int done_dly, input logic redir, input logic [63:0] tgt,
                           input logic late);
    logic [63:0] npc;
    e_req = 1'b1;
    e_ivalid = 1'b0;
    e_retire = 1'b0;
    imem_rsp_valid = late;
    imem_rsp_data = EBREAK;
    for (int i = 0; i < rdy_dly; i++) begin
      imem_req_ready = 1'b0;
      cyc();
    end
    imem_req_ready = 1'b1;
    cyc();
    // Fetch wait; a stray execute completion must be ignored here.
    imem_req_ready = 1'b0;
    e_req = 1'b0;
    exu_done = 1'b1;
    exu_redirect = 1'b1;
    exu_next_pc = 64'h3;
    for (int i = 0; i < rsp_dly; i++) begin
      imem_rsp_valid = 1'b0;
      cyc();
    end
    exu_done = 1'b0;
    exu_redirect = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = ins;
    cyc();
    // Decode
    imem_rsp_valid = 1'b0;
    m_inst = ins;
    e_ivalid = 1'b1;
    if (ins == EBREAK) begin
      e_retire = 1'b1;
      cyc();
      e_retire = 1'b0;
      e_ivalid = 1'b0;
      m_halt = 1'b1;
      m_trap = 2'd0;
      m_instret = m_instret + 64'd1;
      return;
    end
    cyc();
    e_ivalid = 1'b0;
    // Execute
    npc = redir ? tgt : m_pc + 64'd4;
    for (int k = 0; k < int'(TO); k++) begin
      if (k == done_dly) begin
        exu_done = 1'b1;
        exu_redirect = redir;
        exu_next_pc = tgt;
        e_retire = 1'b1;
        cyc();
        exu_done = 1'b0;
        exu_redirect = 1'b0;
        e_retire = 1'b0;
        m_instret = m_instret + 64'd1;
        if (npc[1:0] != 2'b00) begin
          m_halt = 1'b1;
          m_trap = 2'd1;
        end else begin
          m_pc = npc;
          e_req = 1'b1;
        end
        return;
      end
      cyc();
    end
    m_halt = 1'b1;
    m_trap = 2'd2;
  endtask

  // Halted: poke every input and expect nothing to move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'h0000_0013;
      exu_done = 1'b1;
      exu_redirect = i[0];
      exu_next_pc = 64'h8000_0200;
      cyc();
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    exu_done = 1'b0;
    exu_redirect = 1'b0;
  endtask

  initial begin
    int s;
    check_en = 1'b0;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0;
    exu_done = 1'b0;
    exu_redirect = 1'b0;
    exu_next_pc = 64'd0;
`ifdef YSYX_22040632_INSTRET_EN
    lit_ir = 64'd1;
`else
    lit_ir = 64'd0;
`endif
    cyc();
    check_en = 1'b1;
    do_reset();

    // Zero-wait memory, immediate execute completion.
    chk("first_addr", imem_req_addr, 64'h8000_0000);
    s = cyc_n;
    run_instr(32'h0000_0013, 0, 0, 0, 1'b0, 64'd0, 1'b0);
    chk("min_latency", 64'(last_ret - s + 1), 64'd4);
    chk("pc_plus4", pc, 64'h8000_0004);

    // Stalled memory, taken redirect.
    run_instr(32'h0000_0463, 2, 1, 2, 1'b1, 64'h8000_0100, 1'b0);
    chk("redirect_addr", imem_req_addr, 64'h8000_0100);

    // Target ignored when not redirecting, even if misaligned.
    run_instr(ADDI, 0, 0, 1, 1'b0, 64'h2, 1'b0);
    chk("no_redirect_pc", pc, 64'h8000_0104);

    // Wrap at the top of the address space.
    run_instr(JAL, 0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    run_instr(ADDI, 0, 0, 0, 1'b0, 64'd0, 1'b0);
    chk("wrap_pc", pc, 64'd0);

    // Reset in the middle of a stalled fetch.
    e_req = 1'b1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    do_reset();
    chk("refetch_addr", imem_req_addr, 64'h8000_0000);
    chk("reset_instret", instret, 64'd0);

    // Misaligned redirect halts after retiring.
    run_instr(JAL, 0, 0, 0, 1'b1, 64'h8000_0102, 1'b1);
    idle(5);
    chk("misalign_halt", {63'd0, halt}, 64'd1);
    chk("misalign_trap", {62'd0, trap}, 64'd1);
    chk("misalign_pc", pc, 64'h8000_0000);

    // ebreak
    do_reset();
    run_instr(EBREAK, 1, 0, 0, 1'b0, 64'd0, 1'b1);
    idle(5);
    chk("ebreak_halt", {63'd0, halt}, 64'd1);
    chk("ebreak_trap", {62'd0, trap}, 64'd0);
    chk("ebreak_instret", instret, lit_ir);
    chk("ebreak_no_req", {63'd0, imem_req_valid}, 64'd0);

    // Execute timeout after one retired instruction.
    do_reset();
    run_instr(ADDI, 0, 0, 0, 1'b0, 64'd0, 1'b0);
    run_instr(ADDI, 0, 0, int'(TO) + 5, 1'b0, 64'd0, 1'b0);
    idle(4);
    chk("timeout_halt", {63'd0, halt}, 64'd1);
    chk("timeout_trap", {62'd0, trap}, 64'd2);
    chk("timeout_instret", instret, lit_ir);
    chk("timeout_pc", pc, 64'h8000_0004);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22040632_mc_ctrl.md
YSYX_22040632_MC_CTRL -- requirements
Module: ysyx_22040632_mc_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 'h8000_0000, first fetch address.
REQ-003 SHALL have parameter EXEC_TIMEOUT, default 255, max cycles EXEC waits for exu_done before trapping.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req_valid  output  1  fetch request pending.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  XLEN  fetch address, equal to pc.
REQ-009 imem_rsp_valid  input  1  instruction word returned.
REQ-010 imem_rsp_data  input  32  returned instruction.
REQ-011 inst  output  32  latched instruction for decode.
REQ-012 inst_valid  output  1  one-cycle pulse: inst valid for IDU/EXU.
REQ-013 exu_done  input  1  execute finished this cycle.
REQ-014 exu_redirect  input  1  qualified by exu_done: take exu_next_pc instead of pc+4.
REQ-015 exu_next_pc  input  XLEN  branch/jump target.
REQ-016 pc  output  XLEN  architectural PC of current instruction.
REQ-017 retire  output  1  one-cycle pulse per completed instruction.
REQ-018 halt  output  1  core stopped (sticky).
REQ-019 trap  output  2  halt cause: 0 ebreak, 1 misaligned target, 2 exec timeout.
REQ-020 instret  output  64  retired-instruction count.

Function
REQ-021 FSM states SHALL be RESET, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, HALT.
REQ-022 RESET SHALL move to FETCH_REQ on first clock after rst_n deasserts.
REQ-023 FETCH_REQ SHALL assert imem_req_valid, hold addr stable, move to FETCH_WAIT when valid&&ready.
REQ-024 FETCH_WAIT SHALL latch imem_rsp_data into inst on imem_rsp_valid and move to DECODE; a response in the same cycle as acceptance SHALL be ignored until FETCH_WAIT.
REQ-025 DECODE SHALL pulse inst_valid for exactly one cycle; if inst==32'h0010_0073 (ebreak) move to HALT with trap=0, else move to EXEC.
REQ-026 EXEC SHALL wait for exu_done; on it, pulse retire, increment instret, update pc, return to FETCH_REQ.
REQ-027 Next pc SHALL be exu_next_pc if exu_redirect else pc+4, modulo 2^XLEN (wrap at top, no trap).
REQ-028 If selected next pc has bits[1:0]!=0, SHALL not update pc, SHALL retire, enter HALT with trap=1.
REQ-029 If exu_done not seen within EXEC_TIMEOUT cycles of EXEC entry, SHALL enter HALT with trap=2, no retire.
REQ-030 exu_done outside EXEC SHALL be ignored.
REQ-031 ebreak SHALL count as retired: retire pulse and instret increment in the DECODE->HALT cycle; pc unchanged.
REQ-032 HALT SHALL be absorbing until reset; no outputs change except halt=1.
REQ-033 Minimum latency per instruction SHALL be 4 cycles (FETCH_REQ, FETCH_WAIT, DECODE, EXEC) with zero-wait memory and exu_done in first EXEC cycle.

Reset
REQ-034 On rst_n low, SHALL immediately force: state RESET, pc=RESET_PC, inst=0, inst_valid=0, imem_req_valid=0, retire=0, halt=0, trap=0, instret=0.
REQ-035 Reset mid-fetch SHALL abandon the request; a late imem_rsp_valid after reset SHALL be ignored until FETCH_WAIT.

Configuration
REQ-036 Macro YSYX_22040632_INSTRET_EN defined: instret SHALL be a 64-bit counter per REQ-026/031, wrapping at 2^64.
REQ-037 Macro undefined: instret SHALL be constant 0 and no counter register exists; all other behaviour identical.

Verification
REQ-038 Reset release, ready=1, rsp next cycle with addi, exu_done in first EXEC cycle -> imem_req_addr=0x8000_0000, retire at cycle 4, pc=0x8000_0004.
REQ-039 exu_done with exu_redirect=1, exu_next_pc=0x8000_0100 -> next imem_req_addr=0x8000_0100.
REQ-040 exu_next_pc=0x8000_0102 redirect -> halt=1, trap=1, pc stays 0x8000_0000, retire pulse seen.
REQ-041 imem_rsp_data=0x0010_0073 -> one inst_valid pulse, halt=1, trap=0, instret=1 (macro on), no further requests.
REQ-042 EXEC_TIMEOUT=4, exu_done held low -> halt=1, trap=2 after 4 EXEC cycles, instret unchanged.
REQ-043 imem_req_ready low 3 cycles then rst_n pulse -> all outputs at reset values, fetch restarts at 0x8000_0000.
